// File: rtl/gcn_coo_aggregator.sv
// gcn_coo_aggregator: buffers FM*WM rows, walks a COO edge list accumulating neighbour rows per node, then picks a per-node argmax class.
// Ports: clk_i, reset_i (async, active-high) | start_i, busy_o, done_o: run control
//        in_valid_i, in_ready_o, in_row_i: row load stream, rows arrive in node order
//        edge_addr_o, coo_src_i, coo_dst_i: edge list read, src/dst combinational from edge_addr_o
//        row_select_i, row_out_o: accumulator readout (0 when out of range)
//        argmax_out_o: per-node winning class | ovf_flag_o, err_flag_o: sticky per-run flags
module gcn_coo_aggregator #(
    parameter int NUM_NODES      = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int ACC_WIDTH      = 20,
    parameter int NUM_EDGES      = 6,
    parameter int SYMMETRIC      = 1,
    parameter int SELF_LOOP      = 0,
    parameter int NODE_BW        = $clog2(NUM_NODES),
    parameter int CLASS_BW       = $clog2(WEIGHT_COLS),
    parameter int EDGE_AW        = $clog2(NUM_EDGES)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        start_i,
    output logic                                        busy_o,
    output logic                                        done_o,
    input  logic                                        in_valid_i,
    output logic                                        in_ready_o,
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  in_row_i,
    output logic [EDGE_AW-1:0]                          edge_addr_o,
    input  logic [NODE_BW-1:0]                          coo_src_i,
    input  logic [NODE_BW-1:0]                          coo_dst_i,
    input  logic [NODE_BW-1:0]                          row_select_i,
    output logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0]       row_out_o,
    output logic [NUM_NODES-1:0][CLASS_BW-1:0]          argmax_out_o,
    output logic                                        ovf_flag_o,
    output logic                                        err_flag_o
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_EDGE, S_ARGMAX, S_DONE} state_t;
    // one bit wider than a node index so a power-of-two node count still compares correctly
    localparam logic [NODE_BW:0]    NODES     = (NODE_BW+1)'(NUM_NODES);
    localparam logic [NODE_BW-1:0]  LAST_NODE = NODE_BW'(NUM_NODES - 1);
    localparam logic [EDGE_AW-1:0]  LAST_EDGE = EDGE_AW'(NUM_EDGES - 1);
    state_t                                      state_q;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  sp_q [NUM_NODES];
    logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0]       acc_q [NUM_NODES];
    logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0]       acc_d [NUM_NODES];
    logic [NUM_NODES-1:0][CLASS_BW-1:0]          argmax_q;
    logic [NODE_BW-1:0]                          cnt_q;
    logic [EDGE_AW-1:0]                          edge_q;
    logic                                        busy_q, done_q, ready_q, ovf_q, err_q;
    logic                                        src_ok, dst_ok, edge_ok, edge_ovf;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  row_s, row_d;
    logic [ACC_WIDTH:0]                          sum;
    logic [ACC_WIDTH-1:0]                        best;
    logic [CLASS_BW-1:0]                         best_idx;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign in_ready_o   = ready_q;
    assign edge_addr_o  = edge_q;
    assign argmax_out_o = argmax_q;
    assign ovf_flag_o   = ovf_q;
    assign err_flag_o   = err_q;
    assign row_out_o    = ({1'b0, row_select_i} < NODES) ? acc_q[row_select_i] : '0;
    // next accumulator image for the current edge; the carry bit of each sum drives saturation
    always_comb begin
        src_ok   = {1'b0, coo_src_i} < NODES;
        dst_ok   = {1'b0, coo_dst_i} < NODES;
        edge_ok  = src_ok && dst_ok;
        row_s    = src_ok ? sp_q[coo_src_i] : '0;
        row_d    = dst_ok ? sp_q[coo_dst_i] : '0;
        acc_d    = acc_q;
        edge_ovf = 1'b0;
        sum      = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                if (edge_ok && NODE_BW'(n) == coo_dst_i) begin
                    sum          = {1'b0, acc_q[n][c]} + (ACC_WIDTH+1)'(row_s[c]);
                    acc_d[n][c]  = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                    edge_ovf     = edge_ovf | sum[ACC_WIDTH];
                end
                // a self edge contributes once, so the reverse direction only applies when s != d
                if (SYMMETRIC != 0 && edge_ok && NODE_BW'(n) == coo_src_i && coo_src_i != coo_dst_i) begin
                    sum          = {1'b0, acc_q[n][c]} + (ACC_WIDTH+1)'(row_d[c]);
                    acc_d[n][c]  = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                    edge_ovf     = edge_ovf | sum[ACC_WIDTH];
                end
            end
        end
    end
    // strict greater-than keeps the lowest column on ties
    always_comb begin
        best     = acc_q[cnt_q][0];
        best_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (acc_q[cnt_q][c] > best) begin
                best     = acc_q[cnt_q][c];
                best_idx = CLASS_BW'(c);
            end
        end
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            for (int n = 0; n < NUM_NODES; n++) begin
                sp_q[n]  <= '0;
                acc_q[n] <= '0;
            end
            argmax_q <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= S_LOAD;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b1;
                    ovf_q   <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                S_LOAD: if (in_valid_i) begin
                    sp_q[cnt_q] <= in_row_i;
                    cnt_q       <= (cnt_q == LAST_NODE) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_NODE) begin
                        ready_q <= 1'b0;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    for (int n = 0; n < NUM_NODES; n++)
                        for (int c = 0; c < WEIGHT_COLS; c++)
                            acc_q[n][c] <= (SELF_LOOP != 0) ? ACC_WIDTH'(sp_q[n][c]) : '0;
                    edge_q  <= '0;
                    state_q <= S_EDGE;
                end
                S_EDGE: begin
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_q | edge_ovf;
                    err_q   <= err_q | ~edge_ok;
                    edge_q  <= (edge_q == LAST_EDGE) ? '0 : edge_q + 1'b1;
                    state_q <= (edge_q == LAST_EDGE) ? S_ARGMAX : S_EDGE;
                end
                S_ARGMAX: begin
                    argmax_q[cnt_q] <= best_idx;
                    cnt_q           <= (cnt_q == LAST_NODE) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_NODE) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcn_coo_aggregator.sv
// tb_gcn_coo_aggregator: directed checks of the COO aggregator in default, self-loop/directed and narrow-accumulator builds.
module tb_gcn_coo_aggregator;
    localparam int NN = 6;
    logic clk = 1'b0;
    logic reset, start, in_valid;
    logic [2:0][15:0] in_row;
    logic [2:0] coo_src, coo_dst, row_sel;
    logic [2:0][15:0] rows [NN];
    logic [2:0] src_tab [NN];
    logic [2:0] dst_tab [NN];
    int checks = 0;
    int fails = 0;
    int cyc_cnt = 0;
    logic d_busy, d_done, d_rdy, d_ovf, d_err, s_busy, s_done, s_rdy, s_ovf, s_err, n_busy, n_done, n_rdy, n_ovf, n_err;
    logic [2:0] d_ea, s_ea, n_ea;
    logic [2:0][19:0] d_ro, s_ro;
    logic [2:0][15:0] n_ro;
    logic [5:0][1:0] d_am, s_am, n_am;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    assign coo_src = src_tab[d_ea];
    assign coo_dst = dst_tab[d_ea];
    gcn_coo_aggregator u_def (
        .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(d_busy), .done_o(d_done),
        .in_valid_i(in_valid), .in_ready_o(d_rdy), .in_row_i(in_row), .edge_addr_o(d_ea),
        .coo_src_i(coo_src), .coo_dst_i(coo_dst), .row_select_i(row_sel), .row_out_o(d_ro),
        .argmax_out_o(d_am), .ovf_flag_o(d_ovf), .err_flag_o(d_err));
    gcn_coo_aggregator #(.SELF_LOOP(1), .SYMMETRIC(0)) u_sl (
        .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(s_busy), .done_o(s_done),
        .in_valid_i(in_valid), .in_ready_o(s_rdy), .in_row_i(in_row), .edge_addr_o(s_ea),
        .coo_src_i(coo_src), .coo_dst_i(coo_dst), .row_select_i(row_sel), .row_out_o(s_ro),
        .argmax_out_o(s_am), .ovf_flag_o(s_ovf), .err_flag_o(s_err));
    gcn_coo_aggregator #(.ACC_WIDTH(16)) u_nar (
        .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(n_busy), .done_o(n_done),
        .in_valid_i(in_valid), .in_ready_o(n_rdy), .in_row_i(in_row), .edge_addr_o(n_ea),
        .coo_src_i(coo_src), .coo_dst_i(coo_dst), .row_select_i(row_sel), .row_out_o(n_ro),
        .argmax_out_o(n_am), .ovf_flag_o(n_ovf), .err_flag_o(n_err));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [47:0] r16(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction
    function automatic logic [59:0] r20(input int a, input int b, input int c);
        return {20'(c), 20'(b), 20'(a)};
    endfunction
    task automatic chk_row(input string tag, input int node, input logic [59:0] e_def,
                           input logic [59:0] e_sl, input logic [47:0] e_nar);
        row_sel = 3'(node);
        #1;
        chk({tag, "_def"}, d_ro, e_def);
        chk({tag, "_sl"}, s_ro, e_sl);
        chk({tag, "_nar"}, n_ro, e_nar);
    endtask
    task automatic set_t1();
        for (int i = 0; i < NN; i++) rows[i] = r16(i + 1, 2 * (i + 1), 3 * (i + 1));
        src_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        dst_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    endtask
    task automatic run(input bit tog, input bit mstart, input bit mrst);
        int i, cyc, last;
        i = 0; cyc = 0; last = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (i < NN && cyc < 100) begin
            in_valid = tog ? (cyc % 3 == 0) : 1'b1;
            in_row = rows[i];
            if (in_valid && d_rdy) begin
                i++;
                last = cyc_cnt;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_beats", 64'(i), 64'(NN));
        cyc = 0;
        while (!d_done && cyc < 100) begin
            start = mstart && d_busy && d_ea == 3'd2;
            if (mrst && d_busy && d_ea == 3'd3) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", d_busy, 0);
                chk("rst_done", d_done, 0);
                chk("rst_ready", d_rdy, 0);
                chk("rst_ea", d_ea, 0);
                chk("rst_row", d_ro, 0);
                chk("rst_argmax", d_am, 0);
                chk("rst_sl_busy", s_busy, 0);
                @(negedge clk) reset = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", d_done, 1);
        chk("latency", 64'(cyc_cnt - last), 14);
        chk("busy_at_done", d_busy, 1);
        @(negedge clk);
        chk("done_pulse", d_done, 0);
        chk("idle_busy", d_busy, 0);
    endtask
    task automatic check_t1(input string tag);
        chk_row({tag, "_r0"}, 0, r20(8, 16, 24), r20(7, 14, 21), r16(8, 16, 24));
        chk_row({tag, "_r1"}, 1, r20(4, 8, 12), r20(3, 6, 9), r16(4, 8, 12));
        chk_row({tag, "_r5"}, 5, r20(6, 12, 18), r20(11, 22, 33), r16(6, 12, 18));
        chk_row({tag, "_r6"}, 6, 0, 0, 0);
        chk({tag, "_am_def"}, d_am, 12'haaa);
        chk({tag, "_am_sl"}, s_am, 12'haaa);
        chk({tag, "_am_nar"}, n_am, 12'haaa);
        chk({tag, "_flags_def"}, {d_ovf, d_err}, 0);
        chk({tag, "_flags_sl"}, {s_ovf, s_err}, 0);
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0; row_sel = '0;
        set_t1();
        repeat (2) @(negedge clk);
        chk("reset_ctl", {d_busy, d_done, d_rdy, d_ovf, d_err}, 0);
        chk("reset_ea", d_ea, 0);
        chk("reset_am", d_am, 0);
        chk_row("reset_r0", 0, 0, 0, 0);
        reset = 1'b0;
        run(0, 0, 0);
        check_t1("t1");
        for (int i = 0; i < NN; i++) rows[i] = (i < 2) ? r16(16'hffff, 1, 0) : '0;
        src_tab = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3};
        dst_tab = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4};
        run(0, 0, 0);
        chk_row("t3_r2", 2, r20(20'h1fffe, 2, 0), r20(20'h1fffe, 2, 0), r16(16'hffff, 2, 0));
        chk_row("t3_r0", 0, 0, r20(16'hffff, 1, 0), 0);
        chk("t3_ovf_nar", n_ovf, 1);
        chk("t3_ovf_def", d_ovf, 0);
        chk("t3_am_def", d_am, 0);
        rows = '{r16(0, 0, 0), r16(9, 9, 9), r16(1, 2, 3), r16(5, 5, 1), r16(0, 0, 0), r16(0, 0, 0)};
        src_tab = '{3'd3, 3'd6, 3'd2, 3'd1, 3'd0, 3'd0};
        dst_tab = '{3'd4, 3'd1, 3'd2, 3'd7, 3'd0, 3'd0};
        run(0, 0, 0);
        chk_row("t4_r1", 1, 0, r20(9, 9, 9), 0);
        chk_row("t4_r2", 2, r20(1, 2, 3), r20(2, 4, 6), r16(1, 2, 3));
        chk_row("t4_r4", 4, r20(5, 5, 1), r20(5, 5, 1), r16(5, 5, 1));
        chk("t4_err", {d_err, s_err, n_err}, 3'b111);
        chk("t4_ovf_nar", n_ovf, 0);
        chk("t4_am_def", d_am, 12'h020);
        chk("t4_am_sl", s_am, 12'h020);
        set_t1();
        run(1, 1, 0);
        check_t1("t5");
        run(0, 0, 1);
        chk("t6_post_busy", d_busy, 0);
        chk("t6_post_am", d_am, 0);
        run(0, 0, 0);
        check_t1("t6");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
